// File: rtl/dma_timing_sequencer_pkg.sv
// dma_timing_pkg: shared types for the DMA timing sequencer.
//   state_t    one-hot S-state encoding; stateIdx_t gives the bit position of each state
//   xfer_t     per-channel transfer type (verify / write / read)
//   svc_t      per-channel service type (demand / single / block)
//   busOut_t   registered bus/strobe outputs of the sequencer
//   MAX_NCH    largest supported channel count
package dma_timing_pkg;

   localparam int MAX_NCH = 8;

   typedef enum int unsigned {
      SI_IDX, S0_IDX, S1_IDX, S2_IDX, S3_IDX, SW_IDX, S4_IDX
   } stateIdx_t;

   // bit n set <=> state with index n (see stateIdx_t)
   typedef enum logic [6:0] {
      SI = 7'b0000001,
      S0 = 7'b0000010,
      S1 = 7'b0000100,
      S2 = 7'b0001000,
      S3 = 7'b0010000,
      SW = 7'b0100000,
      S4 = 7'b1000000
   } state_t;

   typedef enum logic [1:0] {
      XFER_VERIFY  = 2'b00,
      XFER_WRITE   = 2'b01,
      XFER_READ    = 2'b10,
      XFER_ILLEGAL = 2'b11
   } xfer_t;

   typedef enum logic [1:0] {
      SVC_DEMAND  = 2'b00,
      SVC_SINGLE  = 2'b01,
      SVC_BLOCK   = 2'b10,
      SVC_ILLEGAL = 2'b11
   } svc_t;

   typedef struct packed {
      logic hrq;
      logic aen;
      logic adstb;
      logic iorN;
      logic iowN;
      logic memrN;
      logic memwN;
      logic ldAddr;
      logic decCount;
   } busOut_t;

   localparam busOut_t IDLE_OUT = '{hrq: 1'b0, aen: 1'b0, adstb: 1'b0,
                                    iorN: 1'b1, iowN: 1'b1, memrN: 1'b1, memwN: 1'b1,
                                    ldAddr: 1'b0, decCount: 1'b0};

   // The illegal mode code behaves as verify.
   function automatic xfer_t decodeXfer(input logic [1:0] m);
      return (m == 2'b11) ? XFER_VERIFY : xfer_t'(m);
   endfunction

   // The illegal service code behaves as single.
   function automatic svc_t decodeSvc(input logic [1:0] m);
      return (m == 2'b11) ? SVC_SINGLE : svc_t'(m);
   endfunction

endpackage

// File: rtl/dma_timing_sequencer_if.sv
// DMA bus handshake interface.
//   dreq / dack          per-channel request / one-hot acknowledge
//   hrq / hlda           hold request / acknowledge with the CPU
//   aen / adstb          address enable / upper-address strobe
//   ior_n iow_n memr_n memw_n   active-low bus strobes
//   eop_n_in / eop_n_out end-of-process in (external) and out (terminal count)
//   ready                slow-device ready
// master = the DMA sequencer, slave = the system side.
interface dma_timing_sequencer_if #(parameter int NCH = 4);

   logic [NCH-1:0] dreq;
   logic [NCH-1:0] dack;
   logic           hrq;
   logic           hlda;
   logic           aen;
   logic           adstb;
   logic           ior_n;
   logic           iow_n;
   logic           memr_n;
   logic           memw_n;
   logic           eop_n_in;
   logic           eop_n_out;
   logic           ready;

   modport master (
      input  dreq, hlda, eop_n_in, ready,
      output hrq, aen, adstb, dack, ior_n, iow_n, memr_n, memw_n, eop_n_out
   );

   modport slave (
      output dreq, hlda, eop_n_in, ready,
      input  hrq, aen, adstb, dack, ior_n, iow_n, memr_n, memw_n, eop_n_out
   );

endinterface

// File: rtl/dma_timing_sequencer_arb.sv
// dma_prio_arbiter: picks one requesting channel.
//   CLK, RESET   clock, synchronous active-high reset
//   req          per-channel requests
//   rotate       1 = rotating priority, 0 = fixed (ch0 highest)
//   advance      pulse: the channel on lastServed finished a service
//   lastServed   channel that just finished; it becomes lowest priority
//   grant        winning channel index
//   valid        at least one request present
module dma_prio_arbiter #(
   parameter  int NCH = 4,
   localparam int CHW = $clog2(NCH)
) (
   input  logic           CLK,
   input  logic           RESET,
   input  logic [NCH-1:0] req,
   input  logic           rotate,
   input  logic           advance,
   input  logic [CHW-1:0] lastServed,
   output logic [CHW-1:0] grant,
   output logic           valid
);

   logic [CHW-1:0] rotLast;   // lowest-priority channel in rotating mode
   logic [CHW-1:0] base;      // highest-priority channel this arbitration
   logic [CHW-1:0] idxC;
   int             idx;

   // Reset value NCH-1 makes ch0 highest for the first rotating arbitration.
   always_ff @(posedge CLK) begin
      if (RESET)        rotLast <= CHW'(NCH - 1);
      else if (advance) rotLast <= lastServed;
   end

   // Scan from lowest to highest priority so the highest-priority
   // requester is the last assignment and wins.
   always_comb begin
      base  = '0;
      grant = '0;
      idx   = 0;
      idxC  = '0;
      if (rotate)
         base = (rotLast == CHW'(NCH - 1)) ? '0 : rotLast + CHW'(1);
      for (int i = NCH - 1; i >= 0; i--) begin
         idx = int'(base) + i;
         if (idx >= NCH) idx = idx - NCH;
         idxC = CHW'(idx);
         if (req[idxC]) grant = idxC;
      end
   end

   assign valid = |req;

endmodule

// File: rtl/dma_timing_sequencer.sv
// dma_timing_sequencer: N-channel DMA timing/control sequencer.
//   CLK, RESET         clock, synchronous active-high reset
//   bus (master)       DREQ/DACK, HRQ/HLDA, AEN/ADSTB, bus strobes, EOP in/out, READY
//   cmd_compressed     compressed timing (S2 -> S4, no S3/SW)
//   cmd_ext_write      extended write (write strobe from S2)
//   cmd_rotate         rotating priority
//   mode_xfer/mode_svc per-channel 2-bit transfer and service modes
//   tc, addr_hi_change datapath status for the active channel
//   ld_addr, dec_count datapath strobes
//   act_ch             granted channel, valid while hrq=1
//   tc_set             one-cycle pulse setting the channel's status TC bit
// Strobes, dack, hrq, aen, adstb, ld_addr and dec_count are registered
// decodes of the next state. eop_n_out and tc_set are decoded from the
// registered state together with tc / eop_n_in of the same S4 cycle.
module dma_timing_sequencer
   import dma_timing_pkg::*;
#(
   parameter  int NCH = 4,
   localparam int CHW = $clog2(NCH)
) (
   input  logic                  CLK,
   input  logic                  RESET,
   dma_timing_sequencer_if.master bus,
   input  logic                  cmd_compressed,
   input  logic                  cmd_ext_write,
   input  logic                  cmd_rotate,
   input  logic [2*NCH-1:0]      mode_xfer,
   input  logic [2*NCH-1:0]      mode_svc,
   input  logic                  tc,
   input  logic                  addr_hi_change,
   output logic                  ld_addr,
   output logic                  dec_count,
   output logic [CHW-1:0]        act_ch,
   output logic [NCH-1:0]        tc_set
);

   state_t               state, nextState;
   logic [CHW-1:0]       actCh;
   logic [CHW-1:0]       arbGrant;
   logic                 arbValid;
   logic                 advance;
   logic                 eopHeld;    // eop_n_in seen during S1..SW, acted on in S4
   logic                 eopNow;
   logic [NCH-1:0][1:0]  xferVec, svcVec;
   xfer_t                actXfer;
   svc_t                 actSvc;
   logic [NCH-1:0]       chOneHot;
   busOut_t              outReg, nxtOut;
   logic [NCH-1:0]       dackReg, nxtDack;
   logic                 inXfer, wrPhase;

   assign xferVec  = mode_xfer;
   assign svcVec   = mode_svc;
   assign actXfer  = decodeXfer(xferVec[actCh]);
   assign actSvc   = decodeSvc(svcVec[actCh]);
   assign chOneHot = NCH'(1) << actCh;
   assign eopNow   = eopHeld | ~bus.eop_n_in;

   // Rotation advances on every end of service; fixed mode ignores it.
   assign advance = (state == S4) && (nextState == SI);

   dma_prio_arbiter #(.NCH(NCH)) uArb (
      .CLK        (CLK),
      .RESET      (RESET),
      .req        (bus.dreq),
      .rotate     (cmd_rotate),
      .advance    (advance),
      .lastServed (actCh),
      .grant      (arbGrant),
      .valid      (arbValid)
   );

   // next state
   always_comb begin
      nextState = state;
      unique case (state)
         SI: if (arbValid) nextState = S0;
         S0: begin
            if (!bus.eop_n_in) nextState = SI;
            else if (bus.hlda) nextState = S1;
         end
         S1: nextState = S2;
         S2: nextState = cmd_compressed ? S4 : S3;
         S3: nextState = bus.ready ? S4 : SW;
         SW: if (bus.ready) nextState = S4;
         S4: begin
            // tc, eop, single/hold loss and demand drop all end the service
            if (tc || eopNow || actSvc == SVC_SINGLE || !bus.hlda ||
                (actSvc == SVC_DEMAND && !bus.dreq[actCh]))
               nextState = SI;
            else
               nextState = addr_hi_change ? S1 : S2;
         end
         default: nextState = SI;
      endcase
   end

   // output decode of the next state
   always_comb begin
      nxtOut  = IDLE_OUT;
      nxtDack = '0;
      inXfer  = nextState inside {S2, S3, SW, S4};
      wrPhase = (nextState inside {S3, SW, S4}) ||
                (nextState == S2 && (cmd_compressed || cmd_ext_write));
      nxtOut.hrq      = (nextState != SI);
      nxtOut.aen      = inXfer || (nextState == S1);
      nxtOut.adstb    = (nextState == S1);
      // address latch on S1, or on S2 when a continuing transfer skips S1
      nxtOut.ldAddr   = (nextState == S1) || (state == S4 && nextState == S2);
      nxtOut.decCount = (nextState == S4);
      nxtOut.iorN     = !(inXfer  && actXfer == XFER_WRITE);
      nxtOut.memrN    = !(inXfer  && actXfer == XFER_READ);
      nxtOut.memwN    = !(wrPhase && actXfer == XFER_WRITE);
      nxtOut.iowN     = !(wrPhase && actXfer == XFER_READ);
      if (inXfer) nxtDack = chOneHot;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= SI;
         actCh   <= '0;
         eopHeld <= 1'b0;
         outReg  <= IDLE_OUT;
         dackReg <= '0;
      end else begin
         state   <= nextState;
         outReg  <= nxtOut;
         dackReg <= nxtDack;
         // grant frozen for the whole service
         if (state == SI && arbValid) actCh <= arbGrant;
         if (state == SI || state == S4)
            eopHeld <= 1'b0;
         else if (state != S0 && !bus.eop_n_in)
            eopHeld <= 1'b1;
      end
   end

   assign bus.hrq       = outReg.hrq;
   assign bus.aen       = outReg.aen;
   assign bus.adstb     = outReg.adstb;
   assign bus.ior_n     = outReg.iorN;
   assign bus.iow_n     = outReg.iowN;
   assign bus.memr_n    = outReg.memrN;
   assign bus.memw_n    = outReg.memwN;
   assign bus.dack      = dackReg;
   assign ld_addr       = outReg.ldAddr;
   assign dec_count     = outReg.decCount;
   assign act_ch        = actCh;

   // tc wins over eop: one tc_set pulse either way, eop_n_out only on tc
   assign bus.eop_n_out = !(state == S4 && tc);
   assign tc_set        = (state == S4 && (tc || eopNow)) ? chOneHot : '0;

endmodule

// File: tb/tb_dma_timing_sequencer.sv
// Bench for dma_timing_sequencer (NCH=4). Each cycle the driver sets the
// inputs for the current S-state and pushes the expected outputs of that
// state; a checker pops one entry per cycle on the falling edge.
module tb_dma_timing_sequencer;

   typedef enum {SI, S0, S1, S2, S3, SW, S4} tst_e;

   typedef struct {
      string       tag;
      logic [19:0] val;
      logic [19:0] mask;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       cmd_compressed = 1'b0;
   logic       cmd_ext_write = 1'b0;
   logic       cmd_rotate = 1'b0;
   logic [7:0] mode_xfer = '0;
   logic [7:0] mode_svc = '0;
   logic       tc = 1'b0;
   logic       addr_hi_change = 1'b0;
   logic       ld_addr, dec_count;
   logic [1:0] act_ch;
   logic [3:0] tc_set;

   int   chkCnt = 0;
   int   errCnt = 0;
   exp_t sb[$];

   int       expCh = 0;
   logic [1:0] expXfer = 2'b00;
   tst_e     prevSt = SI;

   dma_timing_sequencer_if #(.NCH(4)) bus();

   dma_timing_sequencer #(.NCH(4)) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .bus            (bus),
      .cmd_compressed (cmd_compressed),
      .cmd_ext_write  (cmd_ext_write),
      .cmd_rotate     (cmd_rotate),
      .mode_xfer      (mode_xfer),
      .mode_svc       (mode_svc),
      .tc             (tc),
      .addr_hi_change (addr_hi_change),
      .ld_addr        (ld_addr),
      .dec_count      (dec_count),
      .act_ch         (act_ch),
      .tc_set         (tc_set)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chkCnt++;
      if (obs !== exp) begin
         errCnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // expected outputs of one S-state
   // layout: hrq aen adstb dack[3:0] ior iow memr memw eopo ld dec act[1:0] tcset[3:0]
   function automatic logic [19:0] expVec(input tst_e st, input logic [3:0] ts, input logic eo);
      logic       rd, wr, isW, isR;
      logic [3:0] dk;
      rd  = st inside {S2, S3, SW, S4};
      wr  = (st inside {S3, SW, S4}) || (st == S2 && (cmd_compressed || cmd_ext_write));
      isW = (expXfer == 2'b01);
      isR = (expXfer == 2'b10);
      dk  = rd ? (4'b0001 << expCh) : 4'b0000;
      return {st != SI, st inside {S1, S2, S3, SW, S4}, st == S1, dk,
              !(rd && isW), !(wr && isR), !(rd && isR), !(wr && isW), eo,
              st == S1 || (st == S2 && prevSt == S4), st == S4,
              2'(expCh), ts};
   endfunction

   task automatic want(input string tag, input tst_e st, input logic [3:0] ts, input logic eo);
      exp_t e;
      e.tag  = $sformatf("%s_%s", tag, st.name());
      e.val  = expVec(st, ts, eo);
      e.mask = (st == SI) ? 20'hFFFCF : 20'hFFFFF;   // act_ch only meaningful while hrq=1
      if (st == SI) e.val[5:4] = 2'b00;
      sb.push_back(e);
      prevSt = st;
   endtask

   // advance one cycle and expect state st for it
   task automatic cy(input string tag, input tst_e st, input logic [3:0] ts = 4'b0000,
                     input logic eo = 1'b1);
      @(posedge CLK);
      #1;
      want(tag, st, ts, eo);
   endtask

   task automatic doReset(input string tag);
      RESET = 1'b1;
      bus.dreq = '0;
      bus.hlda = 1'b0;
      bus.eop_n_in = 1'b1;
      bus.ready = 1'b1;
      tc = 1'b0;
      addr_hi_change = 1'b0;
      cmd_compressed = 1'b0;
      cmd_ext_write = 1'b0;
      cy(tag, SI);
      @(negedge CLK);
      chk({tag, "_actch"}, {30'b0, act_ch}, 32'd0);
      RESET = 1'b0;
   endtask

   // scoreboard checker
   initial begin
      exp_t        e;
      logic [19:0] obs;
      forever begin
         @(negedge CLK);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            obs = {bus.hrq, bus.aen, bus.adstb, bus.dack, bus.ior_n, bus.iow_n,
                   bus.memr_n, bus.memw_n, bus.eop_n_out, ld_addr, dec_count, act_ch, tc_set};
            chk(e.tag, {12'b0, obs & e.mask}, {12'b0, e.val & e.mask});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      bus.dreq = '0;
      bus.hlda = 1'b0;
      bus.eop_n_in = 1'b1;
      bus.ready = 1'b1;

      // fixed priority, ch1 single write, hlda after 2 cycles
      doReset("rst0");
      mode_xfer = 8'b00000100; mode_svc = 8'b00000100;
      expCh = 1; expXfer = 2'b01;
      cy("t1", SI); bus.dreq = 4'b0110;
      cy("t1", S0);
      cy("t1", S0); bus.hlda = 1'b1;
      cy("t1", S1);
      cy("t1", S2);
      cy("t1", S3);
      cy("t1", S4); bus.dreq = '0;
      cy("t1", SI); bus.hlda = 1'b0;

      // rotating priority, all channels single
      doReset("rst1");
      cmd_rotate = 1'b1;
      mode_xfer = 8'b01010101; mode_svc = 8'b01010101;
      expXfer = 2'b01;
      cy("t2", SI); bus.dreq = 4'b1111; bus.hlda = 1'b1;
      for (int g = 0; g < 5; g++) begin
         expCh = g % 4;
         if (g > 0) cy("t2", SI);
         cy("t2", S0);
         cy("t2", S1);
         cy("t2", S2);
         cy("t2", S3);
         cy("t2", S4);
         if (g == 4) bus.dreq = '0;
      end
      cy("t2", SI); bus.hlda = 1'b0;
      cmd_rotate = 1'b0;

      // ch2 block read, S1 re-entered once, tc on 3rd transfer
      mode_xfer = 8'b00100000; mode_svc = 8'b00100000;
      expCh = 2; expXfer = 2'b10;
      cy("t3", SI); bus.dreq = 4'b0100; bus.hlda = 1'b1;
      cy("t3", S0);
      cy("t3", S1);
      cy("t3", S2);
      cy("t3", S3);
      cy("t3", S4);
      cy("t3", S2);
      cy("t3", S3);
      cy("t3", S4); addr_hi_change = 1'b1;
      cy("t3", S1); addr_hi_change = 1'b0;
      cy("t3", S2);
      cy("t3", S3);
      cy("t3", S4, 4'b0100, 1'b0); tc = 1'b1; bus.dreq = '0;
      cy("t3", SI); tc = 1'b0; bus.hlda = 1'b0;

      // ch0 single write with 3 wait states, then compressed repeat
      mode_xfer = 8'b00000001; mode_svc = 8'b00000001;
      expCh = 0; expXfer = 2'b01;
      cy("t4", SI); bus.dreq = 4'b0001; bus.hlda = 1'b1;
      cy("t4", S0);
      cy("t4", S1);
      cy("t4", S2);
      cy("t4", S3); bus.ready = 1'b0;
      cy("t4", SW);
      cy("t4", SW);
      cy("t4", SW); bus.ready = 1'b1;
      cy("t4", S4);
      cy("t4c", SI); cmd_compressed = 1'b1; bus.ready = 1'b0;
      cy("t4c", S0);
      cy("t4c", S1);
      cy("t4c", S2);
      cy("t4c", S4); bus.dreq = '0;
      cy("t4c", SI); bus.hlda = 1'b0; cmd_compressed = 1'b0; bus.ready = 1'b1;

      // ch3 demand read with extended write, request drops after 2nd transfer
      mode_xfer = 8'b10000000; mode_svc = 8'b00000000;
      expCh = 3; expXfer = 2'b10;
      cy("t5", SI); bus.dreq = 4'b1000; bus.hlda = 1'b1; cmd_ext_write = 1'b1;
      cy("t5", S0);
      cy("t5", S1);
      cy("t5", S2);
      cy("t5", S3);
      cy("t5", S4);
      cy("t5", S2);
      cy("t5", S3);
      cy("t5", S4); bus.dreq = '0;
      cy("t5", SI); bus.hlda = 1'b0; cmd_ext_write = 1'b0;

      // ch1 block, illegal xfer code (verify), eop in S2 ends service
      mode_xfer = 8'b00001100; mode_svc = 8'b00001000;
      expCh = 1; expXfer = 2'b00;
      cy("t6", SI); bus.dreq = 4'b0010; bus.hlda = 1'b1;
      cy("t6", S0);
      cy("t6", S1);
      cy("t6", S2); bus.eop_n_in = 1'b0;
      cy("t6", S3); bus.eop_n_in = 1'b1;
      cy("t6", S4, 4'b0010, 1'b1); bus.dreq = '0;
      cy("t6", SI); bus.hlda = 1'b0;

      // ch2 block write, reset in S3
      mode_xfer = 8'b00010000; mode_svc = 8'b00100000;
      expCh = 2; expXfer = 2'b01;
      cy("t7", SI); bus.dreq = 4'b0100; bus.hlda = 1'b1;
      cy("t7", S0);
      cy("t7", S1);
      cy("t7", S2);
      cy("t7", S3); RESET = 1'b1;
      cy("t7", SI);
      @(negedge CLK);
      chk("t7_actch", {30'b0, act_ch}, 32'd0);
      RESET = 1'b0; bus.dreq = '0; bus.hlda = 1'b0;
      cy("t7", SI);

      repeat (2) @(negedge CLK);
      chk("sb_drain", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

endmodule
